// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_pkg
// Description : Shared types for the MEM/WB writeback stage: result select,
//               load type and the buffered instruction entry.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_ADDR_W = 5;

  // Result source for the register write
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_t;

  // Load width/sign; encodings outside this list behave as LD_W
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_type_t;

  // One retiring instruction as held in the skid FIFO
  typedef struct packed {
    logic                  reg_write;
    logic [c_ADDR_W-1:0]   rd;
    wb_sel_t               wb_sel;
    load_type_t            load_type;
    logic [1:0]            byte_off;
    logic [c_DATA_W-1:0]   alu_result;
    logic [c_DATA_W-1:0]   mem_data;
    logic [c_DATA_W-1:0]   pc_plus4;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Little-endian load extraction. Picks the addressed byte or
//               halfword out of the raw memory word and sign/zero extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import wb_pkg::*;
(
  input  logic [c_DATA_W-1:0] memData,
  input  load_type_t          loadType,
  input  logic [1:0]          byteOff,
  output logic [c_DATA_W-1:0] alignedData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte and halfword lane selection; halfword ignores the low offset bit
  always_comb begin
    w_byte = memData[7:0];
    case (byteOff)
      2'd0:    w_byte = memData[7:0];
      2'd1:    w_byte = memData[15:8];
      2'd2:    w_byte = memData[23:16];
      default: w_byte = memData[31:24];
    endcase
    w_half = byteOff[1] ? memData[31:16] : memData[15:0];
  end

  // Extension by load type; unknown types pass the full word through
  always_comb begin
    alignedData = memData;
    case (loadType)
      LD_B:    alignedData = {{24{w_byte[7]}}, w_byte};
      LD_BU:   alignedData = {24'd0, w_byte};
      LD_H:    alignedData = {{16{w_half[15]}}, w_half};
      LD_HU:   alignedData = {16'd0, w_half};
      default: alignedData = memData;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB writeback. Two-entry skid FIFO with empty-bypass,
//               result select/alignment, single register-bank write port
//               with a mirrored forwarding copy and a retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_byte_off,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic              wb_stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retired_count
);

  localparam logic [1:0] c_DEPTH = DEPTH[1:0];

  wb_entry_t           r_slot0;
  wb_entry_t           r_slot1;
  logic [1:0]          r_count;
  logic                r_regWrite;
  logic [ADDR_W-1:0]   r_writeReg;
  logic [DATA_W-1:0]   r_writeData;
  logic [31:0]         r_retired;

  wb_entry_t           w_inEntry;
  wb_entry_t           w_popEntry;
  logic                w_push;
  logic                w_pop;
  logic [DATA_W-1:0]   w_alignedData;
  logic [DATA_W-1:0]   w_selData;
  logic                w_doWrite;

  // Ready depends only on the registered occupancy and is held low in reset
  assign in_ready = rst && (r_count < c_DEPTH);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !wb_stall && ((r_count != 2'd0) || w_push);

  // Pack the incoming instruction; an empty FIFO lets it bypass to the output
  always_comb begin
    w_inEntry            = '0;
    w_inEntry.reg_write  = in_reg_write;
    w_inEntry.rd         = in_rd;
    w_inEntry.wb_sel     = wb_sel_t'(in_wb_sel);
    w_inEntry.load_type  = load_type_t'(in_load_type);
    w_inEntry.byte_off   = in_byte_off;
    w_inEntry.alu_result = in_alu_result;
    w_inEntry.mem_data   = in_mem_data;
    w_inEntry.pc_plus4   = in_pc_plus4;
    w_popEntry           = (r_count == 2'd0) ? w_inEntry : r_slot0;
  end

  load_align u_loadAlign (
    .memData     (w_popEntry.mem_data),
    .loadType    (w_popEntry.load_type),
    .byteOff     (w_popEntry.byte_off),
    .alignedData (w_alignedData)
  );

  // Result select and write qualification for the entry being retired
  always_comb begin
    w_selData = w_popEntry.alu_result;
    case (w_popEntry.wb_sel)
      WB_MEM:  w_selData = w_alignedData;
      WB_LINK: w_selData = w_popEntry.pc_plus4;
      default: w_selData = w_popEntry.alu_result;
    endcase
    w_doWrite = w_popEntry.reg_write && (w_popEntry.rd != '0) &&
                (w_popEntry.wb_sel != WB_RSVD);
  end

  // Skid FIFO: slot0 is always the oldest entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        if (r_count == 2'd2) r_slot0 <= r_slot1;
        else if (r_count == 2'd1 && w_push) r_slot0 <= w_inEntry;
      end else if (w_push) begin
        if (r_count == 2'd0) r_slot0 <= w_inEntry;
        else r_slot1 <= w_inEntry;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: loaded only on a pop, write enable pulses for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
      r_retired   <= 32'd0;
    end else if (w_pop) begin
      r_regWrite  <= w_doWrite;
      r_writeReg  <= w_popEntry.rd;
      r_writeData <= w_selData;
      r_retired   <= r_retired + 32'd1;
    end else begin
      r_regWrite  <= 1'b0;
    end
  end

  assign RegWrite      = r_regWrite;
  assign WriteRegister = r_writeReg;
  assign WriteData     = r_writeData;
  assign fwd_valid     = r_regWrite;
  assign fwd_rd        = r_writeReg;
  assign fwd_data      = r_writeData;
  assign retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc_plus4;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_load_type  (in_load_type),
    .in_byte_off   (in_byte_off),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .in_pc_plus4   (in_pc_plus4),
    .wb_stall      (wb_stall),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .retired_count (retired_count)
  );

  // Present one instruction on the input (stimulus only)
  task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc);
    in_valid = 1'b1; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_load_type = lt; in_byte_off = off; in_alu_result = alu;
    in_mem_data = mem; in_pc_plus4 = pc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", in_ready); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWrite); end
    checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL reset_wreg got %0d exp 0", WriteRegister); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", WriteData); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", retired_count); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(1'b1, 5'd8, 2'b00, 3'd0, 2'd0, 32'h1234ABCD, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite got %b exp 1", RegWrite); end
    checks++; if (WriteRegister !== 5'd8) begin errors++; $display("FAIL alu_wreg got %0d exp 8", WriteRegister); end
    checks++; if (WriteData !== 32'h1234ABCD) begin errors++; $display("FAIL alu_wdata got %h exp 1234abcd", WriteData); end
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL alu_count got %0d exp 1", retired_count); end
    @(negedge clk);
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL alu_pulse got %b exp 0", RegWrite); end
  endtask

  // Back-to-back loads, one retiring per cycle through the bypass path
  task automatic test_load_align();
    logic [2:0]  lt  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0]  off [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    drive(1'b1, 5'd1, 2'b01, lt[0], off[0], 32'hDEAD0000, 32'h80FF7F01, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (WriteData !== exp[i] || WriteRegister !== 5'(i + 1) || RegWrite !== 1'b1) begin
        errors++;
        $display("FAIL load_%0d got rw=%b rd=%0d data=%h exp rw=1 rd=%0d data=%h",
                 i, RegWrite, WriteRegister, WriteData, i + 1, exp[i]);
      end
      if (i < 4) drive(1'b1, 5'(i + 2), 2'b01, lt[i+1], off[i+1], 32'hDEAD0000, 32'h80FF7F01, 32'h0);
      else in_valid = 1'b0;
    end
    checks++; if (retired_count !== 32'd6) begin errors++; $display("FAIL load_count got %0d exp 6", retired_count); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    wb_stall = 1'b1;
    drive(1'b1, 5'd10, 2'b00, 3'd0, 2'd0, 32'hA0A0A0A0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (RegWrite !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_one got rw=%b rdy=%b exp rw=0 rdy=1", RegWrite, in_ready); end
    drive(1'b1, 5'd11, 2'b00, 3'd0, 2'd0, 32'hB1B1B1B1, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (RegWrite !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_full got rw=%b rdy=%b exp rw=0 rdy=0", RegWrite, in_ready); end
    drive(1'b1, 5'd12, 2'b00, 3'd0, 2'd0, 32'hC2C2C2C2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (RegWrite !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got rw=%b rdy=%b exp rw=0 rdy=0", RegWrite, in_ready); end
    wb_stall = 1'b0;
    @(negedge clk);
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd10 || WriteData !== 32'hA0A0A0A0) begin errors++; $display("FAIL drain_first got rw=%b rd=%0d data=%h exp rw=1 rd=10 data=a0a0a0a0", RegWrite, WriteRegister, WriteData); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd11 || WriteData !== 32'hB1B1B1B1) begin errors++; $display("FAIL drain_second got rw=%b rd=%0d data=%h exp rw=1 rd=11 data=b1b1b1b1", RegWrite, WriteRegister, WriteData); end
    @(negedge clk);
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd12 || WriteData !== 32'hC2C2C2C2) begin errors++; $display("FAIL drain_third got rw=%b rd=%0d data=%h exp rw=1 rd=12 data=c2c2c2c2", RegWrite, WriteRegister, WriteData); end
    @(negedge clk);
    checks++; if (RegWrite !== 1'b0 || retired_count !== 32'd9) begin errors++; $display("FAIL drain_done got rw=%b cnt=%0d exp rw=0 cnt=9", RegWrite, retired_count); end
  endtask

  task automatic test_suppressed();
    drive(1'b1, 5'd0, 2'b00, 3'd0, 2'd0, 32'h11111111, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL supp_r0 got %b exp 0", RegWrite); end
    drive(1'b1, 5'd5, 2'b11, 3'd0, 2'd0, 32'h22222222, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (RegWrite !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL supp_rsvd got rw=%b fwd=%b exp 0", RegWrite, fwd_valid); end
    checks++; if (retired_count !== 32'd11) begin errors++; $display("FAIL supp_count got %0d exp 11", retired_count); end
  endtask

  task automatic test_link();
    drive(1'b1, 5'd31, 2'b10, 3'd0, 2'd0, 32'h99999999, 32'h0, 32'h00400018);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd31 || WriteData !== 32'h00400018) begin errors++; $display("FAIL link_write got rw=%b rd=%0d data=%h exp rw=1 rd=31 data=00400018", RegWrite, WriteRegister, WriteData); end
    checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd31 || fwd_data !== 32'h00400018) begin errors++; $display("FAIL link_fwd got v=%b rd=%0d data=%h exp v=1 rd=31 data=00400018", fwd_valid, fwd_rd, fwd_data); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    wb_stall = 1'b1;
    drive(1'b1, 5'd3, 2'b00, 3'd0, 2'd0, 32'h33333333, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd4, 2'b00, 3'd0, 2'd0, 32'h44444444, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0 || retired_count !== 32'd0) begin errors++; $display("FAIL async_reset got rw=%b rd=%0d data=%h cnt=%0d exp all 0", RegWrite, WriteRegister, WriteData, retired_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b exp 0", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    wb_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (RegWrite !== 1'b0 || retired_count !== 32'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_%0d got rw=%b cnt=%0d rdy=%b exp rw=0 cnt=0 rdy=1", i, RegWrite, retired_count, in_ready); end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_wb_sel = '0;
    in_load_type = '0; in_byte_off = '0; in_alu_result = '0; in_mem_data = '0;
    in_pc_plus4 = '0; wb_stall = 1'b0;
    test_reset();
    test_alu();
    test_load_align();
    test_stall();
    test_suppressed();
    test_link();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
